// File: rtl/div_operand_feeder.sv
// Operand sequencer for the 5-bit restoring divider: buffers dividend/divisor pairs,
// drives the divider's shared input bus and start pulse, collects the result and
// returns one record per pair. Start is issued 1 cycle after a pair reaches the FIFO
// head in IDLE, and res_valid follows div_done by 2 cycles. The operand side is
// backpressured only by a full FIFO. The record is held in OUT until res_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   in_*              operand pair, valid/ready
//   div_*             divider interface (bus_in/start out; bus_out/done/zero/ovf in)
//   res_*             result record, valid/ready
//   busy              sequencer not idle
module div_operand_feeder #(
  parameter int W       = 5,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic [W-1:0] div_bus_in,
  output logic         div_start,
  input  logic [W-1:0] div_bus_out,
  input  logic         div_done,
  input  logic         div_zero,
  input  logic         div_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_quotient,
  output logic [W-1:0] res_remainder,
  output logic         res_zero,
  output logic         res_ovf,
  output logic         res_timeout,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CAP_R,
    S_OUT
  } state_t;

  state_t state;

  // Operand FIFO. Storage is not reset; only the pointers and occupancy are.
  logic [W-1:0] fifo_a [DEPTH];
  logic [W-1:0] fifo_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic [W-1:0]  op_divisor;
  logic [CW-1:0] cnt;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  // Pop coincides with the IDLE->LOAD_A transition below.
  assign pop        = (state == S_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_dividend;
      fifo_b[wr_ptr] <= in_divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer. Bus/start outputs are registered, so each state's bus value is
  // loaded on the transition into that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      div_start     <= 1'b0;
      div_bus_in    <= '0;
      op_divisor    <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_zero      <= 1'b0;
      res_ovf       <= 1'b0;
      res_timeout   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            div_start  <= 1'b1;
            div_bus_in <= fifo_a[rd_ptr];
            op_divisor <= fifo_b[rd_ptr];
            busy       <= 1'b1;
            state      <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          // Previous record stays visible until the next pair actually starts.
          res_zero    <= 1'b0;
          res_ovf     <= 1'b0;
          res_timeout <= 1'b0;
          div_start   <= 1'b0;
          div_bus_in  <= op_divisor;
          state       <= S_LOAD_B;
        end
        S_LOAD_B: begin
          div_bus_in <= '0;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (div_done) begin
            res_quotient <= div_bus_out;
            res_zero     <= div_zero;
            res_ovf      <= div_ovf;
            state        <= S_CAP_R;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_quotient  <= '0;
            res_remainder <= '0;
            res_timeout   <= 1'b1;
            res_valid     <= 1'b1;
            state         <= S_OUT;
          end
        end
        S_CAP_R: begin
          // Divider presents the remainder one cycle after done.
          res_remainder <= div_bus_out;
          res_valid     <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_operand_feeder.sv
module tb_div_operand_feeder;

  localparam int W       = 5;
  localparam int TIMEOUT = 31;
  localparam int LAT     = 6;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic [W-1:0] div_bus_in;
  logic         div_start;
  logic [W-1:0] div_bus_out;
  logic         div_done;
  logic         div_zero;
  logic         div_ovf;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_quotient;
  logic [W-1:0] res_remainder;
  logic         res_zero;
  logic         res_ovf;
  logic         res_timeout;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // divider model state / observations
  logic         model_hang = 1'b0;
  logic         model_ovf  = 1'b0;
  logic [W-1:0] cap_a, cap_b;
  logic         cap_start2;
  int           start_cnt = 0;
  int           done_cyc  = 0;

  int acc_cyc, start_cyc, res_cyc, n, s0;

  div_operand_feeder #(.W(W), .DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_bus_in(div_bus_in), .div_start(div_start),
    .div_bus_out(div_bus_out), .div_done(div_done),
    .div_zero(div_zero), .div_ovf(div_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_remainder(res_remainder),
    .res_zero(res_zero), .res_ovf(res_ovf), .res_timeout(res_timeout),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: dividend on start cycle, divisor next, done LAT cycles later
  // with quotient, remainder one cycle after done. Divide by zero: q=all ones, r=dividend.
  initial begin
    div_done    = 1'b0;
    div_bus_out = '0;
    div_zero    = 1'b0;
    div_ovf     = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        start_cnt = start_cnt + 1;
        cap_a = div_bus_in;
        @(negedge clk);
        cap_b      = div_bus_in;
        cap_start2 = div_start;
        if (model_hang) continue;
        repeat (LAT - 1) @(negedge clk);
        div_done    = 1'b1;
        div_zero    = (cap_b == 0);
        div_ovf     = model_ovf;
        div_bus_out = (cap_b == 0) ? 5'h1f : cap_a / cap_b;
        done_cyc    = cyc;
        @(negedge clk);
        div_done    = 1'b0;
        div_zero    = 1'b0;
        div_ovf     = 1'b0;
        div_bus_out = (cap_b == 0) ? cap_a : cap_a % cap_b;
        @(negedge clk);
        div_bus_out = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("push_rdy", {31'b0, in_ready}, 1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!div_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start"}, {31'b0, div_start}, 1);
    start_cyc = cyc;
  endtask

  task automatic get_rec(input string tag, input int q, input int r,
                         input int z, input int o, input int t);
    int k;
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_vld"}, {31'b0, res_valid}, 1);
    res_cyc = cyc;
    check({tag, "_q"}, {27'b0, res_quotient}, q);
    check({tag, "_r"}, {27'b0, res_remainder}, r);
    check({tag, "_z"}, {31'b0, res_zero}, z);
    check({tag, "_o"}, {31'b0, res_ovf}, o);
    check({tag, "_t"}, {31'b0, res_timeout}, t);
    if (res_ready) begin
      @(negedge clk);
      check({tag, "_drop"}, {31'b0, res_valid}, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_vld",   {31'b0, res_valid}, 0);
    check("rst_start", {31'b0, div_start}, 0);
    check("rst_bus",   {27'b0, div_bus_in}, 0);
    check("rst_inrdy", {31'b0, in_ready}, 1);
    check("rst_rec",   {20'b0, res_quotient, res_remainder, res_zero, res_ovf, res_timeout}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: 13/3 -> q=4 r=1, bus sequencing and latency
    push(5'd13, 5'd3);
    in_valid = 1'b0;
    wait_start("t1");
    check("t1_start_lat", start_cyc - acc_cyc, 2);
    get_rec("t1", 4, 1, 0, 0, 0);
    check("t1_res_lat", res_cyc - done_cyc, 2);
    check("t1_bus_a", {27'b0, cap_a}, 13);
    check("t1_bus_b", {27'b0, cap_b}, 3);
    check("t1_pulse", {31'b0, cap_start2}, 0);
    check("t1_idle_bus", {27'b0, div_bus_in}, 0);
    check("t1_idle_busy", {31'b0, busy}, 0);

    // 2: divide by zero passes flag through
    push(5'd9, 5'd0);
    in_valid = 1'b0;
    get_rec("t2", 31, 9, 1, 0, 0);

    // overflow flag passes through unmodified
    model_ovf = 1'b1;
    push(5'd20, 5'd6);
    in_valid = 1'b0;
    get_rec("tovf", 3, 2, 0, 1, 0);
    model_ovf = 1'b0;

    // 3: three back-to-back pairs, FIFO fills, records in order
    push(5'd17, 5'd5);
    push(5'd30, 5'd7);
    push(5'd8, 5'd8);
    in_valid = 1'b0;
    check("t3_full", {31'b0, in_ready}, 0);
    get_rec("t3a", 3, 2, 0, 0, 0);
    get_rec("t3b", 4, 2, 0, 0, 0);
    get_rec("t3c", 1, 0, 0, 0, 0);
    check("t3_reopen", {31'b0, in_ready}, 1);

    // 4: divider never completes -> timeout record, then normal restart
    model_hang = 1'b1;
    push(5'd12, 5'd5);
    in_valid = 1'b0;
    wait_start("t4");
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_tmo_lat", n, TIMEOUT + 2);
    get_rec("t4", 0, 0, 0, 0, 1);
    model_hang = 1'b0;
    push(5'd31, 5'd1);
    in_valid = 1'b0;
    get_rec("t4b", 31, 0, 0, 0, 0);

    // 5: hold res_ready low in OUT
    res_ready = 1'b0;
    push(5'd25, 5'd4);
    in_valid = 1'b0;
    get_rec("t5a", 6, 1, 0, 0, 0);
    s0 = start_cnt;
    check("t5_inrdy", {31'b0, in_ready}, 1);
    push(5'd11, 5'd2);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_hold_vld", {31'b0, res_valid}, 1);
    check("t5_hold_q", {27'b0, res_quotient}, 6);
    check("t5_hold_r", {27'b0, res_remainder}, 1);
    check("t5_no_start", start_cnt, s0);
    check("t5_busy", {31'b0, busy}, 1);
    res_ready = 1'b1;
    @(negedge clk);
    get_rec("t5b", 5, 1, 0, 0, 0);
    check("t5_one_start", start_cnt, s0 + 1);

    // 6: reset during WAIT aborts and empties FIFO
    model_hang = 1'b1;
    push(5'd6, 5'd3);
    in_valid = 1'b0;
    wait_start("t6");
    repeat (4) @(negedge clk);
    push(5'd2, 5'd1);
    in_valid = 1'b0;
    check("t6_busy_pre", {31'b0, busy}, 1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_vld", {31'b0, res_valid}, 0);
    check("t6_inrdy", {31'b0, in_ready}, 1);
    rst = 1'b1;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    check("t6_fifo_empty", start_cnt, s0);
    check("t6_idle", {31'b0, busy}, 0);
    model_hang = 1'b0;
    push(5'd7, 5'd2);
    in_valid = 1'b0;
    get_rec("t6b", 3, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
